// File: rtl/ex_alu_stage.sv
// Execute stage: ALU, branch-condition evaluation, the EX/MEM pipeline register
// and a sticky RUN/HALTED controller with a retired-instruction counter.
module ex_alu_stage #(
   parameter int WORD_SIZE = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [5:0]           ALUControl,
   input  logic                 in_valid,
   input  logic [WORD_SIZE-1:0] op_a,
   input  logic [WORD_SIZE-1:0] op_b,
   input  logic [WORD_SIZE-1:0] store_data,
   input  logic [WORD_SIZE-1:0] pc_plus1,
   input  logic [1:0]           dest_reg,
   input  logic                 reg_write,
   input  logic                 mem_read,
   input  logic                 mem_write,
   input  logic                 is_wwd,
   input  logic                 is_halt,
   input  logic                 stall,
   input  logic                 flush,
   output logic                 branch_taken,
   output logic                 mem_valid,
   output logic                 mem_reg_write,
   output logic                 mem_mem_read,
   output logic                 mem_mem_write,
   output logic                 mem_wwd,
   output logic [WORD_SIZE-1:0] mem_result,
   output logic [WORD_SIZE-1:0] mem_store_data,
   output logic [1:0]           mem_dest,
   output logic                 halted,
   output logic [15:0]          inst_count
);

   typedef enum logic {RUN, HALTED} state_e;

   typedef struct packed {
      logic                 valid;
      logic                 regWrite;
      logic                 memRead;
      logic                 memWrite;
      logic                 wwd;
      logic [WORD_SIZE-1:0] result;
      logic [WORD_SIZE-1:0] storeData;
      logic [1:0]           dest;
   } exMem_t;

   state_e               state_q, state_d;
   exMem_t               exMem_q, exMem_d;
   logic [15:0]          instCount_q, instCount_d;
   logic [WORD_SIZE-1:0] aluResult;
   logic                 branchCond;
   logic                 loadEn;
   logic                 acceptInst;

   assign loadEn     = !flush && !stall;
   assign acceptInst = in_valid && (state_q == RUN);

   always_comb begin
      aluResult = op_a;
      case (ALUControl)
         6'd0:    aluResult = op_a + op_b;
         6'd1:    aluResult = op_a - op_b;
         6'd2:    aluResult = op_a & op_b;
         6'd3:    aluResult = op_a | op_b;
         6'd4:    aluResult = ~op_a;
         6'd5:    aluResult = (~op_a) + WORD_SIZE'(1);
         6'd6:    aluResult = op_a << 1;
         6'd7:    aluResult = $signed(op_a) >>> 1;
         6'd8:    aluResult = op_b << (WORD_SIZE / 2);
         6'd9, 6'd10, 6'd11, 6'd12:
                  aluResult = '0;
         6'd13:   aluResult = pc_plus1;
         default: aluResult = op_a;
      endcase
   end

   always_comb begin
      branchCond = 1'b0;
      case (ALUControl)
         6'd9:    branchCond = (op_a != op_b);
         6'd10:   branchCond = (op_a == op_b);
         6'd11:   branchCond = !op_a[WORD_SIZE-1] && (op_a != '0);
         6'd12:   branchCond = op_a[WORD_SIZE-1];
         default: branchCond = 1'b0;
      endcase
   end

   // Stall does not gate the branch decision; only a halted machine suppresses it.
   assign branch_taken = in_valid && branchCond && (state_q == RUN);

   always_comb begin
      exMem_d = exMem_q;
      if (flush) begin
         exMem_d = '0;
      end else if (!stall) begin
         if (acceptInst) begin
            exMem_d.valid     = 1'b1;
            exMem_d.regWrite  = reg_write;
            exMem_d.memRead   = mem_read;
            exMem_d.memWrite  = mem_write;
            exMem_d.wwd       = is_wwd;
            exMem_d.result    = aluResult;
            exMem_d.storeData = store_data;
            exMem_d.dest      = dest_reg;
         end else begin
            exMem_d = '0;
         end
      end
   end

   always_comb begin
      instCount_d = instCount_q;
      if (loadEn && acceptInst) begin
         instCount_d = instCount_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         exMem_q     <= '0;
         instCount_q <= '0;
      end else begin
         exMem_q     <= exMem_d;
         instCount_q <= instCount_d;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // The halting instruction itself is captured; only later ones become bubbles.
   always_comb begin
      state_d = state_q;
      if ((state_q == RUN) && loadEn && in_valid && is_halt) begin
         state_d = HALTED;
      end
   end

   always_comb begin
      halted = (state_q == HALTED);
   end

   assign mem_valid      = exMem_q.valid;
   assign mem_reg_write  = exMem_q.regWrite;
   assign mem_mem_read   = exMem_q.memRead;
   assign mem_mem_write  = exMem_q.memWrite;
   assign mem_wwd        = exMem_q.wwd;
   assign mem_result     = exMem_q.result;
   assign mem_store_data = exMem_q.storeData;
   assign mem_dest       = exMem_q.dest;
   assign inst_count     = instCount_q;

endmodule

// File: tb/tb_ex_alu_stage.sv
// Randomized bench for ex_alu_stage: a behavioural model queues the expected
// response of every cycle and an independent monitor checks the DUT against it.
module tb_ex_alu_stage;

   typedef struct {
      logic [5:0]  code;
      logic        inValid;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] sdata;
      logic [15:0] pc;
      logic [1:0]  dest;
      logic        rw;
      logic        mr;
      logic        mw;
      logic        wwd;
      logic        halt;
      logic        stall;
      logic        flush;
      logic        rstN;
   } stim_t;

   typedef struct {
      logic        branch;
      logic        valid;
      logic        rw;
      logic        mr;
      logic        mw;
      logic        wwd;
      logic        halted;
      logic [15:0] result;
      logic [15:0] sdata;
      logic [15:0] count;
      logic [1:0]  dest;
   } exp_t;

   logic        clk;
   logic        reset_n;
   logic [5:0]  ALUControl;
   logic        in_valid;
   logic [15:0] op_a, op_b, store_data, pc_plus1;
   logic [1:0]  dest_reg;
   logic        reg_write, mem_read, mem_write, is_wwd, is_halt, stall, flush;
   logic        branch_taken;
   logic        mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_wwd;
   logic [15:0] mem_result, mem_store_data;
   logic [1:0]  mem_dest;
   logic        halted;
   logic [15:0] inst_count;

   ex_alu_stage #(.WORD_SIZE(16)) dut (
      .clk(clk), .reset_n(reset_n), .ALUControl(ALUControl), .in_valid(in_valid),
      .op_a(op_a), .op_b(op_b), .store_data(store_data), .pc_plus1(pc_plus1),
      .dest_reg(dest_reg), .reg_write(reg_write), .mem_read(mem_read),
      .mem_write(mem_write), .is_wwd(is_wwd), .is_halt(is_halt),
      .stall(stall), .flush(flush), .branch_taken(branch_taken),
      .mem_valid(mem_valid), .mem_reg_write(mem_reg_write),
      .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
      .mem_wwd(mem_wwd), .mem_result(mem_result), .mem_store_data(mem_store_data),
      .mem_dest(mem_dest), .halted(halted), .inst_count(inst_count)
   );

   // Scoreboard and model state.
   exp_t expQ[$];
   int   vectors = 0;
   int   miscompares = 0;
   bit   mHalted = 0;
   int   mCount = 0;
   exp_t mReg;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("[TB] FAIL %s: actual 0x%04h, required 0x%04h at %0t", name, act, req, $time);
      end
   endtask

   function automatic int refAlu(int code, int a, int b, int pc);
      case (code)
         0:  return (a + b) % 65536;
         1:  return (a - b + 65536) % 65536;
         2:  return a & b;
         3:  return a | b;
         4:  return 65535 - a;
         5:  return (65536 - a) % 65536;
         6:  return (a * 2) % 65536;
         7:  return a / 2 + ((a >= 32768) ? 32768 : 0);
         8:  return (b % 256) * 256;
         9, 10, 11, 12: return 0;
         13: return pc;
         default: return a;
      endcase
   endfunction

   function automatic bit refBranch(int code, int a, int b);
      int sa;
      sa = (a >= 32768) ? a - 65536 : a;
      case (code)
         9:  return a != b;
         10: return a == b;
         11: return sa > 0;
         12: return sa < 0;
         default: return 1'b0;
      endcase
   endfunction

   function automatic exp_t bubble();
      exp_t e;
      e = '{default: '0};
      return e;
   endfunction

   function automatic stim_t idle();
      stim_t s;
      s = '{default: '0};
      s.rstN = 1'b1;
      return s;
   endfunction

   function automatic stim_t randomStim();
      stim_t s;
      s         = idle();
      s.code    = ($urandom_range(0, 19) == 0) ? 6'($urandom_range(14, 63)) : 6'($urandom_range(0, 13));
      s.inValid = ($urandom_range(0, 3) != 0);
      s.a       = 16'($urandom);
      s.b       = ($urandom_range(0, 5) == 0) ? s.a : 16'($urandom);
      s.sdata   = 16'($urandom);
      s.pc      = 16'($urandom);
      s.dest    = 2'($urandom);
      s.rw      = 1'($urandom);
      s.mr      = 1'($urandom);
      s.mw      = 1'($urandom);
      s.wwd     = 1'($urandom);
      return s;
   endfunction

   task automatic applyStimulus(input stim_t s);
      exp_t e;
      @(negedge clk);
      reset_n    = s.rstN;
      ALUControl = s.code;
      in_valid   = s.inValid;
      op_a       = s.a;
      op_b       = s.b;
      store_data = s.sdata;
      pc_plus1   = s.pc;
      dest_reg   = s.dest;
      reg_write  = s.rw;
      mem_read   = s.mr;
      mem_write  = s.mw;
      is_wwd     = s.wwd;
      is_halt    = s.halt;
      stall      = s.stall;
      flush      = s.flush;
      #1;
      if (!s.rstN) begin
         mHalted  = 1'b0;
         mCount   = 0;
         mReg     = bubble();
         e.branch = s.inValid && refBranch(int'(s.code), int'(s.a), int'(s.b));
      end else begin
         e.branch = !mHalted && s.inValid && refBranch(int'(s.code), int'(s.a), int'(s.b));
         if (s.flush) begin
            mReg = bubble();
         end else if (!s.stall) begin
            if (s.inValid && !mHalted) begin
               mReg.valid  = 1'b1;
               mReg.rw     = s.rw;
               mReg.mr     = s.mr;
               mReg.mw     = s.mw;
               mReg.wwd    = s.wwd;
               mReg.result = 16'(refAlu(int'(s.code), int'(s.a), int'(s.b), int'(s.pc)));
               mReg.sdata  = s.sdata;
               mReg.dest   = s.dest;
               mCount      = (mCount + 1) % 65536;
               if (s.halt) mHalted = 1'b1;
            end else begin
               mReg = bubble();
            end
         end
      end
      e.valid  = mReg.valid;
      e.rw     = mReg.rw;
      e.mr     = mReg.mr;
      e.mw     = mReg.mw;
      e.wwd    = mReg.wwd;
      e.result = mReg.result;
      e.sdata  = mReg.sdata;
      e.dest   = mReg.dest;
      e.halted = mHalted;
      e.count  = 16'(mCount);
      expQ.push_back(e);
   endtask

   // Monitor: branch_taken mid-cycle on settled inputs, registered outputs just after the edge.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         #3;
         if (expQ.size() > 0) begin
            e = expQ[0];
            checkOutput("branch_taken", {15'b0, branch_taken}, {15'b0, e.branch});
            @(posedge clk);
            #1;
            e = expQ.pop_front();
            checkOutput("mem_valid", {15'b0, mem_valid}, {15'b0, e.valid});
            checkOutput("mem_reg_write", {15'b0, mem_reg_write}, {15'b0, e.rw});
            checkOutput("mem_mem_read", {15'b0, mem_mem_read}, {15'b0, e.mr});
            checkOutput("mem_mem_write", {15'b0, mem_mem_write}, {15'b0, e.mw});
            checkOutput("mem_wwd", {15'b0, mem_wwd}, {15'b0, e.wwd});
            checkOutput("mem_result", mem_result, e.result);
            checkOutput("mem_store_data", mem_store_data, e.sdata);
            checkOutput("mem_dest", {14'b0, mem_dest}, {14'b0, e.dest});
            checkOutput("halted", {15'b0, halted}, {15'b0, e.halted});
            checkOutput("inst_count", inst_count, e.count);
         end
      end
   end

   initial begin : stimulus
      stim_t s;
      mReg       = bubble();
      reset_n    = 1'b0;
      ALUControl = '0;
      in_valid   = 1'b0;
      op_a = '0; op_b = '0; store_data = '0; pc_plus1 = '0; dest_reg = '0;
      reg_write = 0; mem_read = 0; mem_write = 0; is_wwd = 0; is_halt = 0;
      stall = 0; flush = 0;

      s = idle(); s.rstN = 1'b0;
      applyStimulus(s);
      applyStimulus(s);

      // Overflowing add, shift-right sign fill and load-high-immediate.
      s = idle(); s.code = 6'd0; s.a = 16'h7FFF; s.b = 16'h0001; s.inValid = 1; s.rw = 1; s.dest = 2'd2;
      applyStimulus(s);
      s = idle(); s.code = 6'd7; s.a = 16'h8002; s.inValid = 1;
      applyStimulus(s);
      s = idle(); s.code = 6'd8; s.b = 16'h12AB; s.inValid = 1;
      applyStimulus(s);

      s = idle(); s.code = 6'd12; s.a = 16'hFFFF; s.inValid = 1;
      applyStimulus(s);
      s = idle(); s.code = 6'd11; s.a = 16'h0000; s.inValid = 1;
      applyStimulus(s);
      s = idle(); s.code = 6'd9; s.a = 16'h0001; s.b = 16'h0002; s.inValid = 0;
      applyStimulus(s);

      // Hold across three stalled cycles, then flush wins over stall.
      s = idle(); s.code = 6'd0; s.a = 16'h1234; s.b = 16'h0101; s.inValid = 1; s.rw = 1; s.dest = 2'd1;
      applyStimulus(s);
      for (int i = 0; i < 3; i++) begin
         s = randomStim(); s.stall = 1; s.inValid = 1;
         applyStimulus(s);
      end
      s = randomStim(); s.stall = 1; s.flush = 1; s.inValid = 1;
      applyStimulus(s);

      s = idle(); s.code = 6'd0; s.a = 16'h0010; s.inValid = 1; s.halt = 1; s.rw = 1;
      applyStimulus(s);
      for (int i = 0; i < 4; i++) begin
         s = randomStim(); s.code = 6'd0; s.inValid = 1;
         if (i == 1) s.code = 6'd10;
         applyStimulus(s);
      end

      // Reset must clear the halted machine without waiting for a clock edge.
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      checkOutput("async halted", {15'b0, halted}, 16'd0);
      checkOutput("async inst_count", inst_count, 16'd0);
      checkOutput("async mem_valid", {15'b0, mem_valid}, 16'd0);
      s = idle(); s.rstN = 1'b0;
      applyStimulus(s);

      for (int i = 0; i < 1500; i++) begin
         s = randomStim();
         s.stall = ($urandom_range(0, 7) == 0);
         s.flush = ($urandom_range(0, 15) == 0);
         s.halt  = ($urandom_range(0, 149) == 0);
         s.rstN  = ($urandom_range(0, 199) != 0);
         applyStimulus(s);
      end

      s = idle(); s.rstN = 1'b0;
      applyStimulus(s);
      for (int i = 0; i < 65536; i++) begin
         s = randomStim(); s.inValid = 1;
         applyStimulus(s);
      end

      repeat (3) @(negedge clk);
      checkOutput("scoreboard drained", 16'(expQ.size()), 16'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
